// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types, phase table and index helper for the stepper sequencer
package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Even entries are single-coil, odd entries are two-phase-on.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Full-step from an even index moves by one to land on a two-phase-on entry.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] delta;
        delta = (half || !idx[0]) ? 3'd1 : 3'd2;
        return (dir == DIR_FWD) ? idx + delta : idx - delta;
    endfunction

endpackage

// File: rtl/stepper_seq_tick.sv
// rtl/stepper_seq_tick.sv - step_tick: step-rate enable pulse generator
module step_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stepper_seq.sv
// rtl/stepper_seq.sv - stepper-motor phase sequencer with start/busy/done handshake
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 500,
    parameter int STEP_W  = 16,
    parameter int POS_W   = 16,
    parameter int HOLD    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic [STEP_W-1:0]       steps,
    input  logic                    stop,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              coils,
    output logic signed [POS_W-1:0] pos
);

    localparam int DIV = CLK_HZ / STEP_HZ;

    state_t              state;
    logic [2:0]          idx;
    logic [STEP_W-1:0]   remaining;
    logic                dir_q;
    logic                half_q;
    logic                tick;
    logic [2:0]          nidx;
    logic                last_step;
    logic [3:0]          idle_coils;

    // Counter is held at zero while idle, so the first tick lands DIV cycles after start.
    step_tick #(
        .DIV (DIV)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign nidx       = next_idx(idx, dir_q, half_q);
    assign last_step  = tick && (remaining == STEP_W'(1));
    assign idle_coils = (HOLD != 0) ? PHASE_TABLE[nidx] : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            coils     <= 4'b0000;
            idx       <= 3'd0;
            pos       <= '0;
            remaining <= '0;
            dir_q     <= DIR_FWD;
            half_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            dir_q     <= dir;
                            half_q    <= half_step;
                            remaining <= steps;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The final step wins over a coincident stop.
                    if (stop && !last_step) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
                        if (HOLD == 0) begin
                            coils <= 4'b0000;
                        end
                    end else if (tick) begin
                        idx       <= nidx;
                        pos       <= (dir_q == DIR_FWD) ? pos + POS_W'(1) : pos - POS_W'(1);
                        remaining <= remaining - STEP_W'(1);
                        if (last_step) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            coils <= idle_coils;
                        end else begin
                            coils <= PHASE_TABLE[nidx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stepper_seq.md
# stepper_seq

Stepper-motor phase sequencer for the motor test bench. It accepts a move command (step count, direction, half/full-step mode) through a start/busy/done handshake. Steps are paced by an internal rate divider derived from the board clock, and the block drives the four coil lines of a unipolar driver (ULN2003-class). It sits downstream of the clock-division logic already used in the motor tests: it consumes the step rate rather than producing one.

## Interface
- `CLK_HZ`, 50000000, input clock frequency in Hz.
- `STEP_HZ`, 500, step rate in Hz. `DIV = CLK_HZ/STEP_HZ` is computed at elaboration and must be ≥ 2.
- `STEP_W`, 16, width of the step-count input.
- `POS_W`, 16, width of the signed position counter.
- `HOLD`, 1. When 1, coils keep the last pattern while idle; when 0, coils are forced to `0000` while idle.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  move request; sampled only while idle.
- `dir`  in  1  direction: 1 = forward, 0 = reverse. Latched on accepted start.
- `half_step`  in  1  mode: 1 = half-step, 0 = full-step (two-phase-on). Latched on accepted start.
- `steps`  in  STEP_W  number of steps to issue. Latched on accepted start.
- `stop`  in  1  abort the current move.
- `busy`  out  1  high while a move is in progress.
- `done`  out  1  one-cycle pulse when a move ends (normal completion, abort, or zero-length move).
- `coils`  out  4  coil drive `{A,B,C,D}`, registered.
- `pos`  out  POS_W  signed step position; two's-complement wrap.

## Operation
- **Phase table** (8 entries, index `idx`): 0:`1000`, 1:`1100`, 2:`0100`, 3:`0110`, 4:`0010`, 5:`0011`, 6:`0001`, 7:`1001`.
- **States:** IDLE and RUN.
- **IDLE:**
  - `start=1` with `steps≠0`: latch `dir`, `half_step` and `steps` into `remaining`; clear the tick counter; go to RUN.
  - `start=1` with `steps=0`: pulse `done`; stay in IDLE; no motion.
- **RUN:**
  - On each tick, apply one step: update `idx`, then `coils` = table[`idx`].
  - On each step, `pos` changes by +1 (forward) or −1 (reverse), in either mode.
  - Decrement `remaining` on each step. The step that brings `remaining` to 0 returns the block to IDLE and pulses `done`.
- **Index update (mod 8):**
  - Half-step: `idx ± 1`.
  - Full-step with `idx` odd: `idx ± 2`.
  - Full-step with `idx` even: `idx ± 1`, which realigns to the two-phase-on patterns.
- **Start while busy:** `start` in RUN is ignored. `dir`, `half_step` and `steps` are not re-sampled.
- **Stop:** `stop=1` in RUN ends the move at the next edge: go to IDLE, pulse `done`, discard `remaining`, and issue no step on that edge.
  - If `stop` coincides with a tick, the step is not issued.
  - If `stop` coincides with the final tick, the final step is issued and there is exactly one `done` pulse.
  - `stop` in IDLE has no effect.
- **Idle coils:** with `HOLD=0`, `coils=0000` whenever the block is in IDLE. `idx` is retained either way.
- **Reset:** takes effect at any time, including mid-move. Reset values: state IDLE, `busy=0`, `done=0`, `coils=0000`, `idx=0`, `pos=0`, tick counter 0, `remaining=0`.

## Timing
- `start` accepted on edge E0 → `busy=1` after E0.
- Tick counter runs 0..DIV−1 and wraps. A tick occurs on the edge where the counter equals DIV−1.
- First coil update is at edge E0+DIV; step k is at edge E0+k·DIV.
- For N steps: the coil update, `busy` falling and the one-cycle `done` pulse all happen together on edge E0+N·DIV. `busy` is high for exactly N·DIV cycles.
- Zero-step start: `done=1` for the single cycle after E0; `busy` stays 0.
- A new `start` is accepted in the cycle `done` is high (the block is already IDLE), so moves can run back-to-back.
- Latency from accepted start to the first coil change is DIV cycles. There is no other pipelining.

## Structure
- Package `stepper_pkg`: state enum (IDLE, RUN), 8-entry phase-table constant, `DIR_FWD`/`DIR_REV` constants.
- Sub-module `step_tick`:
  - Parameter `DIV`; inputs `clk`, `rst`, `clr`; output `tick`, a one-cycle enable pulse.
  - It is the enable-pulse counterpart of a clock divider; it does not generate a derived clock.
- The top level holds the FSM, `idx`, `remaining`, `pos` and the `coils` register.

## Test plan
- **Forward half-step.** `CLK_HZ=100`, `STEP_HZ=10` (DIV=10). After reset, `start` with `steps=4`, `dir=1`, `half_step=1`. Required: coils `1100`, `0100`, `0110`, `0010` at cycles 10/20/30/40; `pos=4`; `done` pulse at cycle 40; `busy` high for 40 cycles.
- **Full-step reverse from even index.** From `idx=0`, `steps=3`, `dir=0`, `half_step=0`. Required: `idx` 7, 5, 3; coils `1001`, `0011`, `0110`; `pos=−3`.
- **Zero-length move.** `steps=0`. Required: one `done` pulse the cycle after start; `busy` never rises; coils unchanged.
- **Stop mid-move.** `steps=10`, assert `stop` at cycle 25. Required: exactly 2 steps issued, `done` at cycle 26, `busy=0` after it. Also check `stop` coinciding with the final tick: one `done`, final step applied.
- **Reset mid-move and ignored start.** Assert `rst` at cycle 15 of an active move: required `coils=0000`, `pos=0`, `busy=0` next cycle. Separately, `start` pulsed while busy must not alter `remaining` or `dir`.
- **HOLD and back-to-back.** With `HOLD=0`, coils read `0000` in IDLE after a move. Back-to-back: `start` asserted in the `done` cycle is accepted.
